// File: rtl/flit_rx_monitor_if.sv
`default_nettype none
// ============================================================================
// Module : flit_rx_monitor_if
// Brief  : Flit receive bus and packet-report signals for flit_rx_monitor.
// Rev    : 1.0  initial release
// ============================================================================
interface flit_rx_monitor_if #(
  parameter int N = 22
) ();
  logic           flit_valid;
  logic [2*N-1:0] flit_data;
  logic           busy;
  logic           pkt_done;
  logic [7:0]     pkt_flits;
  logic [15:0]    pkt_toggles;
  logic           pkt_err;
  logic [15:0]    pkt_count;

  // Flit source side
  modport master (
    output flit_valid, flit_data,
    input  busy, pkt_done, pkt_flits, pkt_toggles, pkt_err, pkt_count
  );

  // Monitor side
  modport slave (
    input  flit_valid, flit_data,
    output busy, pkt_done, pkt_flits, pkt_toggles, pkt_err, pkt_count
  );
endinterface
`default_nettype wire

// File: rtl/flit_rx_monitor.sv
`default_nettype none
// ============================================================================
// Module : flit_rx_monitor
// Brief  : Frames incoming flits into packets, accumulates bus bit toggles
//          and reports per-packet flit count, toggle sum and truncation.
// Rev    : 1.0  initial release
// ============================================================================
module flit_rx_monitor #(
  parameter int N       = 22,
  parameter int PAYLOAD = 20,
  parameter int IDLE_TO = 8
) (
  input wire               clk,
  input wire               rst,
  flit_rx_monitor_if.slave bus
);

  localparam logic [7:0] c_payload = 8'(PAYLOAD);
  localparam logic [7:0] c_idle_to = 8'(IDLE_TO);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECV   = 2'd1,
    ST_REPORT = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;

  logic [2*N-1:0] r_last_flit;
  logic [7:0]     r_flit_cnt;
  logic [15:0]    r_tog_sum;
  logic [7:0]     r_idle_cnt;
  logic [7:0]     r_pkt_flits;
  logic [15:0]    r_pkt_toggles;
  logic           r_pkt_err;
  logic [15:0]    r_pkt_count;

  logic [2*N-1:0] w_diff;
  logic [15:0]    w_pop;
  logic [16:0]    w_sum_ext;
  logic [15:0]    w_sum_sat;
  logic [7:0]     w_flit_cnt_nxt;
  logic [15:0]    w_tog_nxt;
  logic [7:0]     w_idle_nxt;
  logic           w_report;
  logic           w_report_err;

  // Toggle contribution of the flit on the bus against the bus history
  always_comb begin
    w_diff = bus.flit_data ^ r_last_flit;
    w_pop  = 16'd0;
    for (int i = 0; i < 2*N; i++) begin
      w_pop = w_pop + 16'(w_diff[i]);
    end
    w_sum_ext = {1'b0, r_tog_sum} + {1'b0, w_pop};
    w_sum_sat = w_sum_ext[16] ? 16'hFFFF : w_sum_ext[15:0];
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_flit_cnt_nxt = r_flit_cnt;
    w_tog_nxt      = r_tog_sum;
    w_idle_nxt     = r_idle_cnt;
    w_report       = 1'b0;
    w_report_err   = 1'b0;

    case (r_state)
      ST_IDLE, ST_REPORT: begin
        if (bus.flit_valid) begin
          // A flit here opens a new packet; a one-flit packet completes at once
          w_flit_cnt_nxt = 8'd1;
          w_tog_nxt      = w_pop;
          w_idle_nxt     = 8'd0;
          if (c_payload == 8'd1) begin
            w_state_nxt = ST_REPORT;
            w_report    = 1'b1;
          end else begin
            w_state_nxt = ST_RECV;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end

      ST_RECV: begin
        if (bus.flit_valid) begin
          w_flit_cnt_nxt = r_flit_cnt + 8'd1;
          w_tog_nxt      = w_sum_sat;
          w_idle_nxt     = 8'd0;
          if (w_flit_cnt_nxt == c_payload) begin
            w_state_nxt = ST_REPORT;
            w_report    = 1'b1;
          end
        end else begin
          w_idle_nxt = r_idle_cnt + 8'd1;
          if (w_idle_nxt == c_idle_to) begin
            w_state_nxt  = ST_REPORT;
            w_report     = 1'b1;
            w_report_err = 1'b1;
          end
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Report registers load on the edge entering REPORT so they are valid with pkt_done
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_flit   <= '0;
      r_flit_cnt    <= 8'd0;
      r_tog_sum     <= 16'd0;
      r_idle_cnt    <= 8'd0;
      r_pkt_flits   <= 8'd0;
      r_pkt_toggles <= 16'd0;
      r_pkt_err     <= 1'b0;
      r_pkt_count   <= 16'd0;
    end else begin
      r_flit_cnt <= w_flit_cnt_nxt;
      r_tog_sum  <= w_tog_nxt;
      r_idle_cnt <= w_idle_nxt;
      if (bus.flit_valid) begin
        r_last_flit <= bus.flit_data;
      end
      if (w_report) begin
        r_pkt_flits   <= w_flit_cnt_nxt;
        r_pkt_toggles <= w_tog_nxt;
        r_pkt_err     <= w_report_err;
        r_pkt_count   <= r_pkt_count + 16'd1;
      end
    end
  end

  assign bus.busy        = (r_state == ST_RECV);
  assign bus.pkt_done    = (r_state == ST_REPORT);
  assign bus.pkt_flits   = r_pkt_flits;
  assign bus.pkt_toggles = r_pkt_toggles;
  assign bus.pkt_err     = r_pkt_err;
  assign bus.pkt_count   = r_pkt_count;

endmodule
`default_nettype wire

// File: doc/flit_rx_monitor.md
FLIT_RX_MONITOR -- requirements
Module: flit_rx_monitor

Interface
REQ-001 SHALL have parameter N, default 22: width of one flit half, matching the adder operand width.
REQ-002 SHALL have parameter PAYLOAD, default 20: flits per complete packet, range 1..255.
REQ-003 SHALL have parameter IDLE_TO, default 8: consecutive idle cycles that end a truncated packet, range 1..255.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port flit_valid, input, 1: flit_data is a flit this cycle.
REQ-007 SHALL have port flit_data, input, 2N: {input2 half [2N-1:N], input1 half [N-1:0]}.
REQ-008 SHALL have port busy, output, 1: a packet is in progress (state RECV).
REQ-009 SHALL have port pkt_done, output, 1: one-cycle pulse; report outputs are updated.
REQ-010 SHALL have port pkt_flits, output, 8: flit count of the last reported packet.
REQ-011 SHALL have port pkt_toggles, output, 16: bit toggles of the last reported packet.
REQ-012 SHALL have port pkt_err, output, 1: the last reported packet was truncated (fewer than PAYLOAD flits).
REQ-013 SHALL have port pkt_count, output, 16: number of packets reported since reset.

Function
REQ-014 SHALL implement states IDLE, RECV and REPORT, all registered.
REQ-015 SHALL hold a register last_flit (2N bits) as the bus history; last_flit persists across packets.
REQ-016 SHALL treat each cycle with flit_valid=1 as an accepted flit; there is no backpressure.
REQ-017 On each accepted flit SHALL add popcount(flit_data ^ last_flit), which is 0..2N, to the running toggle sum, then load last_flit with flit_data.
REQ-018 SHALL saturate the running toggle sum at 16'hFFFF.
REQ-019 IDLE: an accepted flit SHALL move to RECV with flit count = 1, toggle sum = that flit's popcount, and idle count = 0.
REQ-020 IDLE: flit_valid=0 SHALL hold IDLE.
REQ-021 RECV: an accepted flit SHALL increment the flit count and clear the idle count.
REQ-022 RECV: flit_valid=0 SHALL increment the idle count.
REQ-023 RECV: the edge that accepts flit number PAYLOAD SHALL move to REPORT with err=0.
REQ-024 RECV: the edge at which the idle count reaches IDLE_TO SHALL move to REPORT with err=1.
REQ-025 REPORT: pkt_done=1 for exactly this one cycle.
REQ-026 REPORT: pkt_flits, pkt_toggles and pkt_err SHALL be loaded from the packet and hold until the next REPORT.
REQ-027 REPORT: pkt_count SHALL increment, wrapping 16'hFFFF -> 0.
REQ-028 REPORT: an accepted flit SHALL start a new packet exactly as in IDLE and move to RECV; no flit is lost.
REQ-029 REPORT: flit_valid=0 SHALL move to IDLE.
REQ-030 Latency: pkt_done SHALL assert in the cycle after the edge that accepts the last flit, or in the cycle after the timeout edge.
REQ-031 When PAYLOAD=1 each accepted flit SHALL produce a REPORT; back-to-back flits SHALL produce consecutive pkt_done pulses.
REQ-032 busy SHALL be 1 only in RECV.
REQ-033 pkt_flits SHALL never exceed PAYLOAD.

Reset
REQ-034 rst=1 SHALL immediately force state IDLE, regardless of clk.
REQ-035 rst=1 SHALL clear last_flit, all counters, busy, pkt_done, pkt_flits, pkt_toggles, pkt_err and pkt_count to 0.
REQ-036 Reset asserted mid-packet SHALL discard the packet with no pkt_done.
REQ-037 The first flit after reset release SHALL start a new packet with toggles counted against last_flit=0.

Verification
REQ-038 Reset, then 20 consecutive flits of all-ones (44 bits) -> single pkt_done; pkt_flits=20, pkt_toggles=44, pkt_err=0, pkt_count=1.
REQ-039 Reset, then 20 flits alternating all-ones/all-zeros, starting all-ones -> pkt_flits=20, pkt_toggles=880, pkt_err=0.
REQ-040 Reset, then 5 flits of 44'h00000000FFF, then flit_valid=0 -> pkt_done in the cycle after the 8th idle edge; pkt_flits=5, pkt_toggles=12, pkt_err=1.
REQ-041 Two 20-flit packets with flit_valid held 1 through the REPORT cycle -> two pkt_done pulses 20 cycles apart; busy low only in the REPORT cycles; pkt_count=2.
REQ-042 Reset asserted asynchronously mid-cycle after 10 flits -> all outputs 0 immediately; no pkt_done; a following 20-flit all-ones packet reports pkt_toggles=44, pkt_count=1.
REQ-043 Packet of 10 flits, 3 idle cycles, 10 more flits -> one packet, pkt_flits=20, pkt_err=0, since an idle count below IDLE_TO is tolerated.
